player_sprite_painter: RTL
==========================

# player_sprite_painter

Upstream pixel source for the object-to-paint selector: owns one player's on-screen position, and on each frame tick moves the sprite per the direction inputs. Each move erases the old WxH box with the background colour, then draws the new box in the sprite colour, one pixel per clock. It produces the per-user VGA_X/VGA_Y/VGA_COLOR/plot_enable stream that the selector arbitrates onto the VGA adapter. It also publishes the current position for bullet spawn logic.

## Interface
- W, 8: sprite width in pixels
- H, 8: sprite height in pixels
- X_INIT, 16: X of the top-left corner after reset
- Y_INIT, 112: Y of the top-left corner after reset
- SPRITE_COLOR, 3'b001: draw colour
- MOVE_STEP, 1: pixels moved per tick per axis
- CLOCK_50  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per frame
- move_left, move_right, move_up, move_down  in  1 each  level direction requests, sampled on frame_tick
- background_color  in  3  erase colour
- obj_X  out  9  current top-left X
- obj_Y  out  8  current top-left Y
- VGA_X  out  9  pixel X
- VGA_Y  out  8  pixel Y
- VGA_COLOR  out  3  pixel colour
- plot_enable  out  1  pixel valid this cycle
- busy  out  1  erase/draw in progress

## Operation
- Screen is 320x240. Legal top-left positions: X in 0..320-W, Y in 0..240-H.
- The FSM has four states: IDLE, ERASE, UPDATE, DRAW.
- IDLE, frame_tick=1: compute the target position.
  - X axis: left only gives X-STEP, clamped at 0; right only gives X+STEP, clamped at 320-W; both or neither leaves X unchanged.
  - Y axis: same rule with up and down, clamped at 0 and 240-H.
  - Target arithmetic is 10-bit, so it never wraps.
  - Target differs from the current position: latch the target, go to ERASE.
  - Target equals the current position: stay in IDLE, emit no pixels.
- ERASE: raster scan of the old box, cx fastest (0..W-1), then cy (0..H-1).
  - One pixel per cycle at (obj_X+cx, obj_Y+cy) in background_color.
  - After the last pixel (cx=W-1, cy=H-1), go to UPDATE.
- UPDATE: one cycle. obj_X/obj_Y take the latched target, counters clear, plot_enable=0. Go to DRAW.
- DRAW: same raster scan at the new position in SPRITE_COLOR. After the last pixel, go to IDLE.
- frame_tick outside IDLE is ignored; it is neither queued nor counted.
- Direction inputs only matter in the IDLE cycle where frame_tick=1.
- background_color is sampled every ERASE cycle, not latched.

## Timing
- All outputs are registered.
- Reset values while rst=1:
  - state=DRAW, cx=cy=0
  - obj_X=X_INIT, obj_Y=Y_INIT
  - VGA_X=0, VGA_Y=0, VGA_COLOR=0
  - plot_enable=0, busy=1
- After reset: first draw pixel appears after the first edge with rst=0. W*H draw pixels follow, then IDLE with busy=0.
- Move timing, with edge E0 the one that samples frame_tick in IDLE:
  - busy=1 from after E0.
  - Erase pixels appear after E1..E(W*H).
  - UPDATE follows E(W*H+1): plot_enable=0, obj_X/obj_Y show the new position.
  - Draw pixels appear after E(W*H+2)..E(2W*H+1).
  - After E(2W*H+2): IDLE, plot_enable=0, busy=0.
- No bubbles inside ERASE or DRAW: plot_enable stays high for exactly W*H consecutive cycles in each.
- Reset asserted mid-ERASE or mid-DRAW:
  - Takes effect at the next edge.
  - Position returns to init and a full redraw at init follows.
  - The partially drawn old box is not erased; clearing is the screen-clear path's job.
- VGA_X max is 319 and VGA_Y max is 239. A pixel outside the screen is a bug.

## Structure
- Shared package holds:
  - SCREEN_W=320, SCREEN_H=240
  - the 3-bit colour constants
  - the state enum (IDLE, ERASE, UPDATE, DRAW)
- Sub-module box_scan_counter:
  - Parameters W, H; inputs clear and advance.
  - Outputs cx, cy and a one-cycle last flag at (W-1, H-1).
  - Reused by the bullet painters.

## Test plan
- Reset release, W=H=8:
  - 64 consecutive plot_enable cycles, colour 001.
  - First pixel (16,112), last pixel (23,119); then busy=0.
- Tick with move_right=1, background 000:
  - 64 erase pixels from (16,112), colour 000.
  - One UPDATE cycle: plot_enable=0, obj_X=17.
  - 64 draw pixels from (17,112); busy drops 130 cycles after the tick edge.
- Clamp: with obj_X=0, tick with move_left=1 gives no pixels and busy stays 0.
  - Likewise at obj_Y=232 with move_down=1.
- Conflicts:
  - Left+right+up on one tick: X unchanged, Y decreases by 1, full erase/draw sequence.
  - Left+right alone: no activity.
- Tick during busy:
  - A second tick at cycle 40 of ERASE is ignored; exactly 128 pixels result.
  - A tick right after busy falls starts a new move.
- Reset at the 30th DRAW pixel: the next pixel stream restarts at (X_INIT, Y_INIT), 64 pixels, colour 001.

Source files
------------

// File: rtl/player_sprite_painter_pkg.sv
// Shared screen geometry, colour constants and painter state
// encoding for the sprite and bullet painters.
package player_sprite_painter_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_CYAN  = 3'b011;
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_UPDATE,
    ST_DRAW
  } state_e;

endpackage

// File: rtl/box_scan_counter.sv
// Raster counter over a WxH box: cx fastest, then cy.
// last is high while the counter sits on (W-1, H-1).
module box_scan_counter #(
  parameter int W = 8,
  parameter int H = 8,
  localparam int CXW = (W > 1) ? $clog2(W) : 1,
  localparam int CYW = (H > 1) ? $clog2(H) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [CXW-1:0] cx,
  output logic [CYW-1:0] cy,
  output logic           last
);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic           x_end, y_end;

  assign x_end = (cx_q == CXW'(W - 1));
  assign y_end = (cy_q == CYW'(H - 1));

  // next position: clear wins, otherwise step the raster
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (advance) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/player_sprite_painter.sv
// Moves one player sprite per frame tick, erasing the old box
// and drawing the new one as a one-pixel-per-clock stream.
module player_sprite_painter
  import player_sprite_painter_pkg::*;
#(
  parameter int         W            = 8,
  parameter int         H            = 8,
  parameter int         X_INIT       = 16,
  parameter int         Y_INIT       = 112,
  parameter logic [2:0] SPRITE_COLOR = COLOR_BLUE,
  parameter int         MOVE_STEP    = 1
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       move_up,
  input  logic       move_down,
  input  logic [2:0] background_color,
  output logic [8:0] obj_X,
  output logic [7:0] obj_Y,
  output logic [8:0] VGA_X,
  output logic [7:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot_enable,
  output logic       busy
);

  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  localparam logic [9:0] STEP  = 10'(MOVE_STEP);
  localparam logic [9:0] MAX_X = 10'(SCREEN_W - W);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_H - H);

  state_e     state_q, state_d;
  logic [8:0] obj_x_q, obj_x_d;
  logic [7:0] obj_y_q, obj_y_d;
  logic [8:0] tgt_x_q, tgt_x_d;
  logic [7:0] tgt_y_q, tgt_y_d;
  logic [8:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] color_q, color_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;

  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           last;
  logic           scan_clear, scan_adv;

  logic [9:0] cur_x, cur_y;
  logic [9:0] nxt_x, nxt_y;
  logic [8:0] px;
  logic [7:0] py;

  box_scan_counter #(
    .W(W),
    .H(H)
  ) u_scan (
    .clk    (CLOCK_50),
    .rst    (rst),
    .clear  (scan_clear),
    .advance(scan_adv),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  assign px = obj_x_q + 9'(cx);
  assign py = obj_y_q + 8'(cy);

  // clamped target; 10-bit so +/-STEP never wraps
  always_comb begin
    cur_x = {1'b0, obj_x_q};
    cur_y = {2'b0, obj_y_q};
    nxt_x = cur_x;
    nxt_y = cur_y;
    unique case (1'b1)
      move_left && !move_right:
        nxt_x = (cur_x < STEP) ? '0 : cur_x - STEP;
      move_right && !move_left:
        nxt_x = (cur_x + STEP > MAX_X) ? MAX_X : cur_x + STEP;
      default: ;
    endcase
    unique case (1'b1)
      move_up && !move_down:
        nxt_y = (cur_y < STEP) ? '0 : cur_y - STEP;
      move_down && !move_up:
        nxt_y = (cur_y + STEP > MAX_Y) ? MAX_Y : cur_y + STEP;
      default: ;
    endcase
  end

  // painter FSM next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    obj_x_d    = obj_x_q;
    obj_y_d    = obj_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    color_d    = color_q;
    plot_d     = 1'b0;
    busy_d     = 1'b1;
    scan_clear = 1'b0;
    scan_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d     = 1'b0;
        scan_clear = 1'b1;
        if (frame_tick &&
            (nxt_x != cur_x || nxt_y != cur_y)) begin
          tgt_x_d = nxt_x[8:0];
          tgt_y_d = nxt_y[7:0];
          busy_d  = 1'b1;
          state_d = ST_ERASE;
        end
      end
      ST_ERASE: begin
        scan_adv = 1'b1;
        plot_d   = 1'b1;
        vga_x_d  = px;
        vga_y_d  = py;
        color_d  = background_color;
        if (last) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        scan_clear = 1'b1;
        obj_x_d    = tgt_x_q;
        obj_y_d    = tgt_y_q;
        state_d    = ST_DRAW;
      end
      ST_DRAW: begin
        scan_adv = 1'b1;
        plot_d   = 1'b1;
        vga_x_d  = px;
        vga_y_d  = py;
        color_d  = SPRITE_COLOR;
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset starts a draw at init
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= ST_DRAW;
      obj_x_q <= 9'(X_INIT);
      obj_y_q <= 8'(Y_INIT);
      tgt_x_q <= 9'(X_INIT);
      tgt_y_q <= 8'(Y_INIT);
      vga_x_q <= '0;
      vga_y_q <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      obj_x_q <= obj_x_d;
      obj_y_q <= obj_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign obj_X       = obj_x_q;
  assign obj_Y       = obj_y_q;
  assign VGA_X       = vga_x_q;
  assign VGA_Y       = vga_y_q;
  assign VGA_COLOR   = color_q;
  assign plot_enable = plot_q;
  assign busy        = busy_q;

endmodule
